// File: rtl/seg7_pkg.sv
// Shared constants and payload types for the eight-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = DIGITS * NIB_W;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DP_BIT = 7;

  // Segment patterns for hex 0..F, bit 0 = segment a; entry 15 is leftmost.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h7b, 7'h5e, 7'h58, 7'h7c, 7'h5f, 7'h6f, 7'h7f,
    7'h27, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

  typedef struct packed {
    logic [DIGITS-1:0] dp;
    logic [DATA_W-1:0] data;
  } disp_t;

endpackage

// File: rtl/seg7_hex2seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex2seg
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed eight-digit seven-segment scanner with frame-aligned double buffering.
// Define SEG7_LZS_EN to blank leading-zero digits (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned P_DIV   = 50000,
  parameter int unsigned P_BLANK = 500
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_load,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [DIGITS-1:0]   i_dp,
  input  logic                i_en,
  output logic [DIGITS-1:0]   o_seg_d,
  output logic [DIGITS-1:0]   o_seg_com,
  output logic                o_frame
);

  localparam int unsigned CW = $clog2(P_DIV);

  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] idx;
  disp_t            shadow;
  disp_t            disp;
  logic             pending;
  logic             disp_valid;

  logic             slot_end_c;
  logic             boundary_c;
  logic             blank_c;
  logic [NIB_W-1:0] nib_c;
  logic [SEG_W-1:0] seg_c;
  logic [SEG_W-1:0] seg_g_c;

  assign slot_end_c = (cnt == CW'(P_DIV - 1));
  assign boundary_c = slot_end_c && (idx == IDX_W'(DIGITS - 1));
  assign blank_c    = (cnt < CW'(P_BLANK)) || !i_en || !disp_valid;
  assign nib_c      = disp.data[{idx, 2'b00} +: NIB_W];

  seg7_hex2seg u_hex2seg (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

`ifdef SEG7_LZS_EN
  logic [DATA_W-1:0] upper_c;
  logic              lz_c;

  // A digit is a leading zero when it and every digit above it are zero.
  assign upper_c = disp.data >> {idx, 2'b00};
  assign lz_c    = (idx != '0) && (upper_c == '0);
  assign seg_g_c = lz_c ? '0 : seg_c;
`else
  assign seg_g_c = seg_c;
`endif

  // Slot counter and digit index, free-running regardless of i_en.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow/display double buffer; display only changes at the frame boundary.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      if (i_load) begin
        shadow <= disp_t'{dp: i_dp, data: i_data};
      end
      if (boundary_c) begin
        if (i_load) begin
          disp       <= disp_t'{dp: i_dp, data: i_data};
          disp_valid <= 1'b1;
        end else if (pending) begin
          disp       <= shadow;
          disp_valid <= 1'b1;
        end
        pending <= 1'b0;
      end else if (i_load) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind the counter state they reflect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_seg_d   <= '0;
      o_seg_com <= '0;
      o_frame   <= 1'b0;
    end else begin
      o_frame <= (cnt == '0) && (idx == '0);
      if (blank_c) begin
        o_seg_d   <= '0;
        o_seg_com <= '0;
      end else begin
        o_seg_com <= DIGITS'(1) << idx;
        o_seg_d   <= {disp.dp[idx], seg_g_c};
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed scoreboard bench for seg7_scan with P_DIV=4, P_BLANK=1.
module tb_seg7_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load;
  logic        en;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  seg_d;
  logic [7:0]  seg_com;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan #(.P_DIV(DIV), .P_BLANK(BLANK)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_load    (load),
    .i_data    (data),
    .i_dp      (dp),
    .i_en      (en),
    .o_seg_d   (seg_d),
    .o_seg_com (seg_com),
    .o_frame   (frame)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] com;
    logic       f;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [6:0]  lut [16];

  // Reference model state
  int          m_c, m_idx;
  logic [31:0] m_sh, m_disp;
  logic [7:0]  m_shdp, m_dispdp;
  logic        m_pend, m_valid;

  // Observation bookkeeping
  logic [7:0]  got [8];
  int          ncyc = 0, last_f = -1, nframe = 0;
  logic        per_chk = 1'b0, seen06 = 1'b0, anycom = 1'b0, hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_idx = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0;
    m_pend = 1'b0; m_valid = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t       e;
    logic [6:0] s;
    e.f = (m_c == 0) && (m_idx == 0);
    if (m_c < BLANK || !en || !m_valid) begin
      e.d = 8'h00; e.com = 8'h00;
    end else begin
      s = lut[m_disp[m_idx*4 +: 4]];
`ifdef SEG7_LZS_EN
      if (m_idx != 0 && (m_disp >> (4 * m_idx)) == 32'h0) s = 7'h00;
`endif
      e.com = 8'(1 << m_idx);
      e.d   = {m_dispdp[m_idx], s};
    end
    return e;
  endfunction

  task automatic model_step();
    logic bnd;
    bnd = (m_c == DIV - 1) && (m_idx == 7);
    if (bnd && load) begin
      m_disp = data; m_dispdp = dp; m_valid = 1'b1; m_pend = 1'b0;
    end else if (bnd && m_pend) begin
      m_disp = m_sh; m_dispdp = m_shdp; m_valid = 1'b1; m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin m_sh = data; m_shdp = dp; end
    if (m_c == DIV - 1) begin m_c = 0; m_idx = (m_idx + 1) % 8; end
    else m_c++;
  endtask

  // One clock: push the expected output for the current state, step, then compare.
  task automatic cyc();
    exp_t e;
    q.push_back(model_out());
    model_step();
    @(posedge clk); #1;
    ncyc++;
    e = q.pop_front();
    chk("seg_d", 32'(seg_d), 32'(e.d));
    chk("seg_com", 32'(seg_com), 32'(e.com));
    chk("frame", 32'(frame), 32'(e.f));
    for (int n = 0; n < 8; n++) if (seg_com == 8'(1 << n)) got[n] = seg_d;
    if (seg_d == 8'h06) seen06 = 1'b1;
    if (seg_com != 8'h00) anycom = 1'b1;
    if (frame) begin
      nframe++;
      if (per_chk && last_f >= 0) chk("frame_period", 32'(ncyc - last_f), 32);
      last_f = ncyc;
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    load = 1'b1; data = d; dp = p;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] exp030 [8];
    lut = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
            7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71};
    exp030 = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h27};
    for (int n = 0; n < 8; n++) got[n] = 8'hxx;
    rstn = 1'b0; load = 1'b0; en = 1'b1; data = '0; dp = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg_d", 32'(seg_d), 0);
    chk("rst_seg_com", 32'(seg_com), 0);
    chk("rst_frame", 32'(frame), 0);
    #3 rstn = 1'b1;

    // Idle: blank until a load reaches the display
    repeat (40) cyc();
    chk("idle_blank", 32'(anycom), 0);

    // Ascending digits
    do_load(32'h76543210, 8'h00);
    per_chk = 1'b1;
    repeat (70) cyc();
    for (int n = 0; n < 8; n++) chk("asc_digit", 32'(got[n]), 32'(exp030[n]));

    // Single nonzero digit with dp
    do_load(32'h0000000A, 8'h01);
    repeat (70) cyc();
    chk("lz_digit0", 32'(got[0]), 32'h000000df);
    for (int n = 1; n < 8; n++) begin
`ifdef SEG7_LZS_EN
      chk("lz_upper", 32'(got[n]), 32'h00000000);
`else
      chk("lz_upper", 32'(got[n]), 32'h0000003f);
`endif
    end

    // Two loads mid-frame: only the later one is shown
    for (int k = 0; k < 40 && m_idx != 3; k++) cyc();
    seen06 = 1'b0;
    do_load(32'h11111111, 8'h00);
    cyc();
    do_load(32'h22222222, 8'h00);
    repeat (70) cyc();
    for (int n = 0; n < 8; n++) chk("overwrite_digit", 32'(got[n]), 32'h0000005b);
    chk("never_1s", 32'(seen06), 0);

    // Load exactly on the boundary cycle
    for (int k = 0; k < 40 && !(m_c == DIV - 1 && m_idx == 7); k++) cyc();
    do_load(32'hFFFFFFFF, 8'h00);
    repeat (33) cyc();
    chk("bnd_digit0", 32'(got[0]), 32'h00000071);

    // Display disabled for a full frame
    en = 1'b0; nframe = 0; anycom = 1'b0;
    repeat (32) cyc();
    chk("en0_frames", 32'(nframe), 1);
    chk("en0_com", 32'(anycom), 0);
    en = 1'b1;
    repeat (8) cyc();

    // Reset during slot 5
    for (int k = 0; k < 40 && !(m_idx == 5 && m_c == 2); k++) cyc();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_seg_d", 32'(seg_d), 0);
    chk("mid_rst_seg_com", 32'(seg_com), 0);
    chk("mid_rst_frame", 32'(frame), 0);
    q.delete();
    model_reset();
    per_chk = 1'b0; last_f = -1;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    do_load(32'h76543210, 8'h00);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cyc();
      if (seg_com != 8'h00) hit = 1'b1;
    end
    chk("first_com_after_rst", 32'(seg_com), 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
